// File: rtl/cordic_pkg.sv
// Shared constants for the circular CORDIC engines: arctangent table, gain
// constants and the vectoring FSM state encoding.
package cordic_pkg;

  localparam real c_CORDIC_GAIN     = 1.6467602581210654;
  localparam real c_CORDIC_INV_GAIN = 0.6072529350088813;
  localparam int  c_ATAN_ENTRIES    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  // atan(2^-i) in binary-angle units for a 32-bit angle word, rescaled with
  // rounding to the requested width.
  function automatic logic [63:0] atan_val(input int width, input int i);
    logic [63:0] base;
    case (i)
      0:  base = 64'h2000_0000;
      1:  base = 64'h12E4_051E;
      2:  base = 64'h09FB_385B;
      3:  base = 64'h0511_11D4;
      4:  base = 64'h028B_0D43;
      5:  base = 64'h0145_D7E1;
      6:  base = 64'h00A2_F61E;
      7:  base = 64'h0051_7C55;
      8:  base = 64'h0028_BE53;
      9:  base = 64'h0014_5F2F;
      10: base = 64'h000A_2F98;
      11: base = 64'h0005_17CC;
      12: base = 64'h0002_8BE6;
      13: base = 64'h0001_45F3;
      14: base = 64'h0000_A2FA;
      15: base = 64'h0000_517D;
      16: base = 64'h0000_28BE;
      17: base = 64'h0000_145F;
      18: base = 64'h0000_0A30;
      19: base = 64'h0000_0518;
      20: base = 64'h0000_028C;
      21: base = 64'h0000_0146;
      22: base = 64'h0000_00A3;
      23: base = 64'h0000_0051;
      24: base = 64'h0000_0029;
      25: base = 64'h0000_0014;
      26: base = 64'h0000_000A;
      27: base = 64'h0000_0005;
      28: base = 64'h0000_0003;
      29: base = 64'h0000_0001;
      30: base = 64'h0000_0001;
      default: base = 64'h0;
    endcase
    if (width < 32) atan_val = (base + (64'd1 << (31 - width))) >> (32 - width);
    else            atan_val = base << (width - 32);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One circular vectoring micro-rotation: steers y toward zero and accumulates
// the applied rotation angle in z.
module cordic_vec_stage #(
  parameter int p_XW = 34,
  parameter int p_ZW = 32,
  parameter int p_SW = 5
) (
  input  logic signed [p_XW-1:0] x,
  input  logic signed [p_XW-1:0] y,
  input  logic        [p_ZW-1:0] z,
  input  logic        [p_SW-1:0] shift,
  input  logic        [p_ZW-1:0] lut,
  output logic signed [p_XW-1:0] x_next,
  output logic signed [p_XW-1:0] y_next,
  output logic        [p_ZW-1:0] z_next
);

  logic signed [p_XW-1:0] x_sh;
  logic signed [p_XW-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  // z wraps modulo 2^p_ZW so results across +/-pi come out right.
  always_comb begin
    if (!y[p_XW-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + lut;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - lut;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative circular-vectoring CORDIC: (x, y) -> (K*|v|, atan2) with one
// micro-rotation per clock and valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for operands
//   ROT   | one micro-rotation per clock, counter = iteration index
//   DONE  | result presented until downstream takes it
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [p_WIDTH+1:0] o_mag,
  output logic [p_WIDTH-1:0] o_angle,
  output logic               o_valid,
  input  logic               i_ready
);

  localparam int c_XW = p_WIDTH + 2;
  localparam int c_CW = $clog2(p_ITER + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(p_ITER - 1);

  if (p_ITER < 1 || p_ITER > p_WIDTH - 2) begin : g_bad_iter
    $error("cordic_vectoring_iter: p_ITER must be within 1..p_WIDTH-2");
  end

  state_e                    st;
  logic [c_CW-1:0]           cnt;
  logic signed [c_XW-1:0]    x_r, y_r, x_n, y_n, x_in, y_in;
  logic [p_WIDTH-1:0]        z_r, z_n, lut;
  logic                      zero_r;
  logic [p_WIDTH-1:0]        atan_rom [2**c_CW];

  for (genvar g = 0; g < 2**c_CW; g++) begin : g_rom
    localparam logic [63:0] c_A = atan_val(p_WIDTH, g);
    assign atan_rom[g] = c_A[p_WIDTH-1:0];
  end

  assign lut  = atan_rom[cnt];
  assign x_in = {{2{i_x[p_WIDTH-1]}}, i_x};
  assign y_in = {{2{i_y[p_WIDTH-1]}}, i_y};

  cordic_vec_stage #(
    .p_XW (c_XW),
    .p_ZW (p_WIDTH),
    .p_SW (c_CW)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .shift  (cnt),
    .lut    (lut),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st      <= IDLE;
      cnt     <= '0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      zero_r  <= 1'b0;
      o_mag   <= '0;
      o_angle <= '0;
    end else begin
      case (st)
        IDLE: if (i_valid) begin
          cnt    <= '0;
          zero_r <= (i_x == '0) && (i_y == '0);
          // Left half-plane: rotate by pi first; guard bits keep -min exact.
          if (i_x[p_WIDTH-1]) begin
            x_r <= -x_in;
            y_r <= -y_in;
            z_r <= {1'b1, {(p_WIDTH-1){1'b0}}};
          end else begin
            x_r <= x_in;
            y_r <= y_in;
            z_r <= '0;
          end
          st <= ROT;
        end
        ROT: begin
          x_r <= x_n;
          y_r <= y_n;
          z_r <= z_n;
          cnt <= cnt + c_CW'(1);
          if (cnt == c_LAST) begin
            st      <= DONE;
            o_mag   <= zero_r ? '0 : x_n;
            o_angle <= zero_r ? '0 : z_n;
          end
        end
        DONE: if (i_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign o_ready = (st == IDLE);
  assign o_valid = (st == DONE);

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter: bit-level algorithm model plus
// a real-valued atan2/hypot sanity check, table vectors, corner sequences, random.
module tb_cordic_vectoring_iter;

  localparam int  W    = 32;
  localparam int  ITER = 16;
  localparam real PI   = 3.14159265358979323846;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [W-1:0]  i_x = '0;
  logic [W-1:0]  i_y = '0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_ready;
  logic [W+1:0]  o_mag;
  logic [W-1:0]  o_angle;
  logic          o_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] atan_tab [ITER];
  real         k_gain;

  typedef struct {
    int          x;
    int          y;
    longint      exp_mag;
    logic [31:0] exp_ang;
  } vec_t;

  vec_t vecs [6];

  always #5 i_clk = ~i_clk;

  cordic_vectoring_iter #(.p_WIDTH(W), .p_ITER(ITER)) u_dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_mag   (o_mag),
    .o_angle (o_angle),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint diff, input longint tol);
    checks++;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: deviation %0d, allowed +/-%0d", nm, diff, tol);
    end
  endtask

  // The algorithm as stated: half-plane pre-rotation, then ITER sign-steered
  // shift-and-add steps on wide integers, angle accumulated modulo 2^32.
  function automatic void model(input int xi, input int yi,
                                output longint mag, output logic [31:0] ang);
    longint x, y, dx, dy;
    logic [31:0] z;
    if (xi == 0 && yi == 0) begin
      mag = 0;
      ang = '0;
      return;
    end
    if (xi < 0) begin
      x = -longint'(xi); y = -longint'(yi); z = 32'h8000_0000;
    end else begin
      x = longint'(xi);  y = longint'(yi);  z = 32'h0;
    end
    for (int i = 0; i < ITER; i++) begin
      dx = x >>> i;
      dy = y >>> i;
      if (y >= 0) begin x = x + dy; y = y - dx; z = z + atan_tab[i]; end
      else        begin x = x - dy; y = y + dx; z = z - atan_tab[i]; end
    end
    mag = x;
    ang = z;
  endfunction

  // Small operands lose angle resolution to shift truncation, so the tolerance
  // widens with 1/|v|; large operands must land within 0x10000 of atan2.
  task automatic chk_real(input string nm, input int xv, input int yv,
                          input longint mag, input logic [31:0] ang);
    real r, a_ref, tol_a;
    longint ai;
    logic [31:0] d;
    if (xv == 0 && yv == 0) return;
    r = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    chk_tol({nm, "_mag_vs_hypot"}, mag - longint'(k_gain * r), 32);
    a_ref = $atan2(real'(yv), real'(xv)) / (2.0 * PI) * 4294967296.0;
    ai = longint'(a_ref);
    d = ang - ai[31:0];
    tol_a = 65536.0 + real'(ITER + 2) / r * 4294967296.0 / (2.0 * PI);
    chk_tol({nm, "_ang_vs_atan2"}, longint'(int'(d)), longint'(tol_a));
  endtask

  task automatic do_op(input int xv, input int yv, input int hold,
                       output longint mag, output logic [31:0] ang, output int lat);
    int n;
    @(negedge i_clk);
    n = 0;
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    chk("ready_before_accept", longint'(o_ready), 1);
    i_x = xv; i_y = yv; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_x = $urandom; i_y = $urandom;
    lat = 0;
    while (!o_valid && lat < 100) begin @(posedge i_clk); #1; lat++; end
    mag = longint'(o_mag);
    ang = o_angle;
    for (int c = 0; c < hold; c++) begin
      @(negedge i_clk);
      i_valid = c[0]; i_x = 1234; i_y = -77;
      @(posedge i_clk); #1;
      chk("hold_valid", longint'(o_valid), 1);
      chk("hold_ready", longint'(o_ready), 0);
      chk("hold_mag",   longint'(o_mag), mag);
      chk("hold_angle", longint'(o_angle), longint'(ang));
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("valid_after_handshake", longint'(o_valid), 0);
  endtask

  task automatic run_checked(input string nm, input int xv, input int yv, input int hold);
    longint m, em;
    logic [31:0] a, ea;
    int lat;
    model(xv, yv, em, ea);
    do_op(xv, yv, hold, m, a, lat);
    chk({nm, "_latency"}, lat, ITER);
    chk({nm, "_mag"}, m, em);
    chk({nm, "_angle"}, longint'(a), longint'(ea));
    chk_real(nm, xv, yv, m, a);
  endtask

  initial begin
    real t;
    longint m, em;
    logic [31:0] a, ea;
    int lat;

    t = 1.0;
    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) begin
      atan_tab[i] = 32'(longint'($atan(t) / (2.0 * PI) * 4294967296.0));
      k_gain = k_gain * $sqrt(1.0 + t * t);
      t = t / 2.0;
    end

    vecs[0] = '{x: 3000,  y: 4000,  exp_mag: 0, exp_ang: '0};
    vecs[1] = '{x: -1000, y: 0,     exp_mag: 0, exp_ang: '0};
    vecs[2] = '{x: 0,     y: 1000,  exp_mag: 0, exp_ang: '0};
    vecs[3] = '{x: 0,     y: -1000, exp_mag: 0, exp_ang: '0};
    vecs[4] = '{x: int'(32'h8000_0000), y: int'(32'h8000_0000), exp_mag: 0, exp_ang: '0};
    vecs[5] = '{x: 0,     y: 0,     exp_mag: 0, exp_ang: '0};
    for (int i = 0; i < 6; i++) begin
      model(vecs[i].x, vecs[i].y, em, ea);
      vecs[i].exp_mag = em;
      vecs[i].exp_ang = ea;
    end

    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_valid", longint'(o_valid), 0);
    chk("reset_mag",   longint'(o_mag), 0);
    chk("reset_angle", longint'(o_angle), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("reset_ready", longint'(o_ready), 1);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].x, vecs[i].y, (i == 5) ? 5 : 0, m, a, lat);
      chk($sformatf("vec%0d_latency", i), lat, ITER);
      chk($sformatf("vec%0d_mag", i), m, vecs[i].exp_mag);
      chk($sformatf("vec%0d_angle", i), longint'(a), longint'(vecs[i].exp_ang));
      chk_real($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, m, a);
    end
    chk("vec4_angle_quadrant", longint'(vecs[4].exp_ang[31:28]), 4'hA);

    // i_valid pulses while in DONE must not have started an operation.
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      chk("no_capture_in_done", longint'(o_ready), 1);
    end

    for (int n = 0; n < 40; n++) begin
      int xv, yv;
      xv = int'($urandom) >>> $urandom_range(0, 24);
      yv = int'($urandom) >>> $urandom_range(0, 24);
      run_checked($sformatf("rand%0d", n), xv, yv, 0);
    end

    // Reset with the iteration counter at 7, then a clean operation.
    run_checked("pre_reset", 3000, 4000, 0);
    @(negedge i_clk);
    i_x = 3000; i_y = 4000; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (7) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("midreset_valid", longint'(o_valid), 0);
    chk("midreset_mag",   longint'(o_mag), 0);
    chk("midreset_angle", longint'(o_angle), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("midreset_ready", longint'(o_ready), 1);
    repeat (ITER + 2) @(posedge i_clk);
    #1;
    chk("midreset_no_result", longint'(o_valid), 0);
    run_checked("post_reset", 3000, 4000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring_iter.md
Name: cordic_vectoring_iter

Overview:
Iterative, single-datapath CORDIC engine in circular vectoring mode. It is the inverse direction of the rotation stages: it drives y to zero, taking (x, y) to magnitude and angle (atan2).
- One micro-rotation per clock.
- Valid/ready handshakes on input and output.
- Feeds polar-conversion and phase-detect users of the accelerator.

Parameters:
p_WIDTH, 32, width of the signed input operands and of the angle word.
p_ITER, 16, number of micro-rotations. Legal range 1..p_WIDTH-2; elaboration error outside it.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_x  input  p_WIDTH  signed x operand.
i_y  input  p_WIDTH  signed y operand.
i_valid  input  1  operand valid.
o_ready  output  1  engine can accept; equals (state==IDLE).
o_mag  output  p_WIDTH+2  unsigned magnitude including CORDIC gain K≈1.646760.
o_angle  output  p_WIDTH  angle in binary-angle format: 2^p_WIDTH ≙ 2π, signed, 0x8000_0000 ≙ ±π.
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, o_valid=0, o_mag=0, o_angle=0, internal x/y/z=0. o_ready=1 once reset deasserts. Any in-flight operation is discarded.
- FSM states:
  - IDLE: o_ready=1. On i_valid&o_ready at an edge, load operands, clear counter, go to ROT.
  - ROT: one micro-rotation per edge. At the edge with counter==p_ITER-1, go to DONE.
  - DONE: o_valid=1; o_mag/o_angle stable. On i_ready at an edge, go to IDLE.
- Latency: with the accept at edge 0, o_valid is high after edge p_ITER. Throughput is one result per p_ITER+2 cycles minimum. o_ready=0 in DONE, so there is no accept in the same cycle as a result handoff.
- Internal x, y are signed p_WIDTH+2 (two guard bits); z is p_WIDTH.
- Load (pre-rotation):
  - If i_x<0: x=-sext(i_x), y=-sext(i_y), z=0x8000_0000 (π).
  - Else: x=sext(i_x), y=sext(i_y), z=0.
  - Negating the most negative value is exact because of the guard bits.
- Micro-rotation i (i = counter value), with arithmetic shift >>>:
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - If y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - All updates use old values.
- z arithmetic wraps modulo 2^p_WIDTH by design. This gives correct wrap across ±π.
- ATAN[i] = round(atan(2^-i)/(2π)·2^p_WIDTH). ATAN[0]=2^(p_WIDTH-3).
- On entry to DONE: o_mag=x (always >=0), o_angle=z. Both outputs are registered and hold until handshake.
- Zero input (i_x==0 and i_y==0): a zero flag is latched at accept. Result is forced to o_mag=0, o_angle=0. Latency is unchanged.
- i_valid while o_ready=0 is ignored; the operands are not captured. i_ready high before o_valid has no effect.
- No gain compensation in this block; downstream multiplies by 1/K.

Decomposition:
- Package cordic_pkg holds:
  - the ATAN function/table, computed from p_WIDTH at elaboration, at least 30 entries;
  - c_CORDIC_GAIN and c_CORDIC_INV_GAIN constants;
  - the FSM state enum {IDLE, ROT, DONE}.
- One combinational sub-module, cordic_vec_stage: inputs x, y, z, shift, lut; outputs next x/y/z. It reuses the stage style of the rotation path.

Test Plan:
- (3000, 4000), p_ITER=16 -> o_angle≈0x25C8_0000 ±0x10000; o_mag≈8234 ±4; o_valid high after edge 16 from accept.
- (-1000, 0) -> pre-rotation path; o_angle=0x8000_0000 ±0x10000; o_mag≈1647 ±4.
- (0, 1000) and (0, -1000) -> o_angle≈0x4000_0000 / 0xC000_0000 ±0x10000; o_mag≈1647 ±4.
- (0x8000_0000, 0x8000_0000) -> no overflow; o_mag≈1.6468·√2·2^31 ±2^4, as a (p_WIDTH+2)-bit value; o_angle≈0xA000_0000 (-3π/4).
- (0, 0) -> o_mag=0, o_angle=0 exactly. Also i_ready held low 5 cycles in DONE: outputs stable and o_ready=0 throughout; pulsing i_valid then does not capture.
- Assert i_rst at counter=7 -> o_valid=0, outputs 0, o_ready=1 after release; next operation (3000, 4000) still gives the correct result.
